reg_file_alu_pipe: RTL and testbench

Parametrised, pipelined successor to the 8-bit register-file/ALU datapath: a 2**ADDR_W x DATA_W register file with two read ports and one write port, feeding an 8-op ALU.
- Operand B comes from RD2 or the external immediate.
- Results and status flags are registered with a valid strobe and written back one cycle later.
- Full forwarding from the write-back stage makes back-to-back dependent operations correct.
- Sits between the instruction sequencer (which drives the issue signals) and downstream datapath consumers of ALUResult/Flags.

---
 rtl/reg_file_alu_pipe.sv | 148 ++++++++++++++
 tb/tb_reg_file_alu_pipe.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/reg_file_alu_pipe.sv
// reg_file_alu_pipe
//   Pipelined register-file + ALU datapath. A 2**ADDR_W x DATA_W register
//   file has two read ports (RA1, RA2) and one write port fed from a
//   one-deep write-back stage. The ALU is combinational in the issue cycle.
//   Result and flags are registered at the end of that cycle, and the result
//   is committed to the register file one edge later. Reads that hit the
//   pending write-back are forwarded from it.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   in_valid         issue strobe; issue inputs are sampled only when high
//   RA1, RA2         operand A / operand B register addresses
//   WA               destination register address
//   RegWrite         write result to WA (qualified by in_valid)
//   ALUSrc           1 = B is external_data_in, 0 = B is RD2
//   ALUControl       ADD,SUB,AND,OR,XOR,SLL,SRL,PASSB (000..111)
//   external_data_in immediate operand
//   ALUResult        registered result
//   out_valid        ALUResult/Flags were updated by the last edge
//   Flags            registered {Z,N,C,V}
module reg_file_alu_pipe #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   input  logic [ADDR_W-1:0] WA,
   input  logic              RegWrite,
   input  logic              ALUSrc,
   input  logic [2:0]        ALUControl,
   input  logic [DATA_W-1:0] external_data_in,
   output logic [DATA_W-1:0] ALUResult,
   output logic              out_valid,
   output logic [3:0]        Flags
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int SH_W  = $clog2(DATA_W);

   logic [DATA_W-1:0] rf [DEPTH];

   // pending write-back stage
   logic              wb_vld;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   // read ports: R0 rule beats forwarding, forwarding beats the array
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];

   assign rd_addr[0] = RA1;
   assign rd_addr[1] = RA2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         if (R0_ZERO && rd_addr[p] == '0)
            rd_data[p] = '0;
         else if (wb_vld && wb_addr == rd_addr[p])
            rd_data[p] = wb_data;
         else
            rd_data[p] = rf[rd_addr[p]];
      end
   end

   // ALU
   logic [DATA_W-1:0] op_a, op_b, res;
   logic [SH_W-1:0]   sh;
   logic [DATA_W:0]   sum, diff, shl, shr;
   logic              c_f, v_f;

   assign op_a = rd_data[0];
   assign op_b = ALUSrc ? external_data_in : rd_data[1];
   assign sh   = op_b[SH_W-1:0];
   assign sum  = {1'b0, op_a} + {1'b0, op_b};
   assign diff = {1'b0, op_a} - {1'b0, op_b};   // MSB is the borrow
   // One spare bit on the far side catches the last bit shifted out;
   // it stays 0 for a zero shift.
   assign shl  = {1'b0, op_a} << sh;
   assign shr  = {op_a, 1'b0} >> sh;

   always_comb begin
      res = '0;
      c_f = 1'b0;
      v_f = 1'b0;
      case (ALUControl)
         3'b000: begin
            res = sum[DATA_W-1:0];
            c_f = sum[DATA_W];
            v_f = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]);
         end
         3'b001: begin
            res = diff[DATA_W-1:0];
            c_f = diff[DATA_W];
            v_f = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]);
         end
         3'b010: res = op_a & op_b;
         3'b011: res = op_a | op_b;
         3'b100: res = op_a ^ op_b;
         3'b101: begin
            res = shl[DATA_W-1:0];
            c_f = shl[DATA_W];
         end
         3'b110: begin
            res = shr[DATA_W:1];
            c_f = shr[0];
         end
         default: res = op_b;
      endcase
   end

   // output registers and write-back stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ALUResult <= '0;
         Flags     <= '0;
         out_valid <= 1'b0;
         wb_vld    <= 1'b0;
         wb_addr   <= '0;
         wb_data   <= '0;
      end else begin
         out_valid <= in_valid;
         wb_vld    <= in_valid & RegWrite;
         // issue fields only load when qualified, so idle-cycle junk never
         // reaches state
         if (in_valid) begin
            ALUResult <= res;
            Flags     <= {res == '0, res[DATA_W-1], c_f, v_f};
            wb_addr   <= WA;
            wb_data   <= res;
         end
      end
   end

   // register-file commit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      end else if (wb_vld && !(R0_ZERO && wb_addr == '0)) begin
         rf[wb_addr] <= wb_data;
      end
   end

endmodule

// File: tb/tb_reg_file_alu_pipe.sv
module tb_reg_file_alu_pipe;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                          XOR_ = 3'd4, SLL = 3'd5, SRL = 3'd6, PASSB = 3'd7;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [3:0] RA1, RA2, WA;
   logic       RegWrite, ALUSrc;
   logic [2:0] ALUControl;
   logic [7:0] external_data_in;
   logic [7:0] ALUResult;
   logic       out_valid;
   logic [3:0] Flags;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_file_alu_pipe #(.DATA_W(8), .ADDR_W(4), .R0_ZERO(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .RA1(RA1), .RA2(RA2), .WA(WA), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
      .ALUControl(ALUControl), .external_data_in(external_data_in),
      .ALUResult(ALUResult), .out_valid(out_valid), .Flags(Flags)
   );

   typedef struct {
      logic       iv;
      logic [3:0] ra1, ra2, wa;
      logic       rw, src;
      logic [2:0] op;
      logic [7:0] ext;
      logic       ev;
      logic [7:0] eres;
      logic [3:0] eflg;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic iv, logic [3:0] ra1, logic [3:0] ra2, logic [3:0] wa,
                               logic rw, logic src, logic [2:0] op, logic [7:0] ext,
                               logic ev, logic [7:0] eres, logic [3:0] eflg);
      vec_t v;
      v.iv = iv; v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.rw = rw; v.src = src;
      v.op = op; v.ext = ext; v.ev = ev; v.eres = eres; v.eflg = eflg;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid = v.iv; RA1 = v.ra1; RA2 = v.ra2; WA = v.wa; RegWrite = v.rw;
      ALUSrc = v.src; ALUControl = v.op; external_data_in = v.ext;
   endtask

   task automatic apply(input vec_t v, input int idx);
      drive(v);
      @(posedge clk);
      #1;
      chk("valid", idx, 32'(out_valid), 32'(v.ev));
      chk("result", idx, 32'(ALUResult), 32'(v.eres));
      chk("flags", idx, 32'(Flags), 32'(v.eflg));
   endtask

   initial begin
      // reset-read sweep: every register reads zero
      for (int i = 0; i < 16; i++)
         tbl.push_back(mk(1, 0, 4'(i), 0, 0, 0, PASSB, 8'h00, 1, 8'h00, 4'b1000));
      // forwarding into the very next issue
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, ADD,   8'h05, 1, 8'h05, 4'b0000));
      tbl.push_back(mk(1, 0, 1, 0, 0, 0, PASSB, 8'h00, 1, 8'h05, 4'b0000));
      // dependent chain
      tbl.push_back(mk(1, 0, 0, 2, 1, 1, ADD,   8'h7F, 1, 8'h7F, 4'b0000));
      tbl.push_back(mk(1, 2, 0, 3, 1, 1, ADD,   8'h01, 1, 8'h80, 4'b0101));
      tbl.push_back(mk(1, 3, 3, 4, 1, 0, ADD,   8'h00, 1, 8'h00, 4'b1011));
      // subtract: borrow, zero, signed overflow
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, PASSB, 8'h03, 1, 8'h03, 4'b0000));
      tbl.push_back(mk(1, 1, 0, 0, 0, 1, SUB,   8'h05, 1, 8'hFE, 4'b0110));
      tbl.push_back(mk(1, 0, 0, 6, 1, 1, ADD,   8'h05, 1, 8'h05, 4'b0000));
      tbl.push_back(mk(1, 6, 0, 0, 0, 1, SUB,   8'h05, 1, 8'h00, 4'b1000));
      tbl.push_back(mk(1, 3, 0, 0, 0, 1, SUB,   8'h01, 1, 8'h7F, 4'b0001));
      // shifts
      tbl.push_back(mk(1, 0, 0, 7, 1, 1, PASSB, 8'h81, 1, 8'h81, 4'b0100));
      tbl.push_back(mk(1, 7, 0, 0, 0, 1, SLL,   8'h01, 1, 8'h02, 4'b0010));
      tbl.push_back(mk(1, 0, 0, 8, 1, 1, PASSB, 8'h01, 1, 8'h01, 4'b0000));
      tbl.push_back(mk(1, 8, 0, 0, 0, 1, SRL,   8'h01, 1, 8'h00, 4'b1010));
      tbl.push_back(mk(1, 7, 0, 0, 0, 1, SLL,   8'h08, 1, 8'h81, 4'b0100));
      tbl.push_back(mk(1, 7, 0, 0, 0, 1, SRL,   8'h07, 1, 8'h01, 4'b0000));
      tbl.push_back(mk(1, 7, 0, 0, 0, 1, SLL,   8'h07, 1, 8'h80, 4'b0100));
      // logic ops and add with carry+overflow
      tbl.push_back(mk(1, 7, 0, 0, 0, 1, AND_,  8'h0F, 1, 8'h01, 4'b0000));
      tbl.push_back(mk(1, 8, 0, 0, 0, 1, OR_,   8'h80, 1, 8'h81, 4'b0100));
      tbl.push_back(mk(1, 7, 0, 0, 0, 1, XOR_,  8'h81, 1, 8'h00, 4'b1000));
      tbl.push_back(mk(1, 7, 0, 0, 0, 1, ADD,   8'h81, 1, 8'h02, 4'b0011));
      // idle with RegWrite high: outputs hold, no write to R9
      tbl.push_back(mk(0, 0, 0, 9, 1, 1, PASSB, 8'h5A, 0, 8'h02, 4'b0011));
      tbl.push_back(mk(1, 0, 9, 0, 0, 0, PASSB, 8'h00, 1, 8'h00, 4'b1000));
      tbl.push_back(mk(1, 0, 2, 0, 0, 0, PASSB, 8'h00, 1, 8'h7F, 4'b0000));
      // back-to-back writes to one register
      tbl.push_back(mk(1, 0, 0, 10, 1, 1, PASSB, 8'h10, 1, 8'h10, 4'b0000));
      tbl.push_back(mk(1, 0, 0, 10, 1, 1, PASSB, 8'h20, 1, 8'h20, 4'b0000));
      tbl.push_back(mk(1, 0, 10, 0, 0, 0, PASSB, 8'h00, 1, 8'h20, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, ADD,    8'h00, 0, 8'h20, 4'b0000));
      tbl.push_back(mk(1, 0, 10, 0, 0, 0, PASSB, 8'h00, 1, 8'h20, 4'b0000));
      // R0 stays zero, no forwarding for WA=0
      tbl.push_back(mk(1, 0, 0, 0, 1, 1, PASSB, 8'hAA, 1, 8'hAA, 4'b0100));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, PASSB, 8'h00, 1, 8'h00, 4'b1000));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, ADD,   8'h00, 1, 8'h00, 4'b1000));
      // idle with junk on every issue input
      tbl.push_back(mk(0, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                       3'($urandom), 8'($urandom), 0, 8'h00, 4'b1000));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, ADD,   8'h00, 1, 8'h00, 4'b1000));

      // reset state
      reset = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, ADD, 8'h00, 0, 8'h00, 4'b0000));
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 0, 32'(out_valid), 32'd0);
      chk("rst_result", 0, 32'(ALUResult), 32'd0);
      chk("rst_flags", 0, 32'(Flags), 32'd0);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // write to R5, then reset during its write-back cycle
      apply(mk(1, 0, 0, 5, 1, 1, PASSB, 8'h33, 1, 8'h33, 4'b0000), 100);
      drive(mk(0, 0, 0, 0, 0, 0, ADD, 8'h00, 0, 8'h00, 4'b0000));
      reset = 1'b0;
      #1;
      chk("midrst_valid", 101, 32'(out_valid), 32'd0);
      chk("midrst_result", 101, 32'(ALUResult), 32'd0);
      chk("midrst_flags", 101, 32'(Flags), 32'd0);
      #2;
      reset = 1'b1;
      apply(mk(1, 0, 5, 0, 0, 0, PASSB, 8'h00, 1, 8'h00, 4'b1000), 102);
      apply(mk(1, 0, 2, 0, 0, 0, PASSB, 8'h00, 1, 8'h00, 4'b1000), 103);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
